bitwise_resp_checker: RTL and testbench

Response-side companion to the stimulus benches that drive the bitwise logic units (and_two and siblings). It accepts a stream of result words over a valid/ready handshake and compacts them into a MISR signature. After a programmed word count it compares the signature against a golden value and reports pass/fail. It is synthesizable, so the same block serves both the simulation benches and on-chip self-test of the ALU logic slice.

---
 rtl/bitwise_resp_checker_pkg.sv | 21 ++
 rtl/bitwise_resp_checker_misr_step.sv | 13 +
 rtl/bitwise_resp_checker.sv | 156 +++++++++++++++
 tb/tb_bitwise_resp_checker.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_resp_checker_pkg.sv
// rtl/bitwise_resp_checker_pkg.sv - shared FSM states, op_sel encodings and MISR defaults
package bitwise_resp_checker_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_RUN   = 2'd1;
   localparam state_t S_CHECK = 2'd2;
   localparam state_t S_DONE  = 2'd3;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } op_sel_e;

   localparam logic [31:0] DEF_MISR_POLY = 32'h04C11DB7;
   localparam logic [31:0] DEF_SEED      = 32'hFFFFFFFF;

endpackage

// File: rtl/bitwise_resp_checker_misr_step.sv
// rtl/bitwise_resp_checker_misr_step.sv - combinational next-signature function of the MISR
module misr_step #(
   parameter int unsigned      width = 32,
   parameter logic [width-1:0] poly  = '0
) (
   input  logic [width-1:0] sig,
   input  logic [width-1:0] word,
   output logic [width-1:0] next_sig
);

   assign next_sig = {sig[width-2:0], 1'b0} ^ (sig[width-1] ? poly : '0) ^ word;

endmodule

// File: rtl/bitwise_resp_checker.sv
// rtl/bitwise_resp_checker.sv - MISR response checker with golden compare
// Optional macro REF_CMP_EN adds per-word operand reference compare and mismatch_cnt.
module bitwise_resp_checker
   import bitwise_resp_checker_pkg::*;
#(
   parameter int unsigned width     = 32,
   parameter int unsigned count_w   = 8,
   parameter logic [31:0] MISR_POLY = DEF_MISR_POLY,
   parameter logic [31:0] SEED      = DEF_SEED
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [count_w-1:0] num_words,
   input  logic [width-1:0]   golden_sig,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [width-1:0]   result,
`ifdef REF_CMP_EN
   input  logic [width-1:0]   op_a,
   input  logic [width-1:0]   op_b,
   input  logic [1:0]         op_sel,
`endif
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [width-1:0]   signature
`ifdef REF_CMP_EN
   ,
   output logic [count_w-1:0] mismatch_cnt
`endif
);

   localparam logic [width-1:0]   POLY_W  = width'(MISR_POLY);
   localparam logic [width-1:0]   SEED_W  = width'(SEED);
   localparam logic [count_w-1:0] CNT_ONE = count_w'(1);

   state_t               state_q, state_d;
   logic [count_w-1:0]   nwords_q, nwords_d;
   logic [count_w-1:0]   cnt_q, cnt_d;
   logic [width-1:0]     golden_q, golden_d;
   logic [width-1:0]     sig_q, sig_d;
   logic                 pass_q, pass_d;
   logic [width-1:0]     sig_step;
   logic                 accept;
   logic                 cmp_ok;

   misr_step #(
      .width (width),
      .poly  (POLY_W)
   ) u_misr_step (
      .sig      (sig_q),
      .word     (result),
      .next_sig (sig_step)
   );

`ifdef REF_CMP_EN
   logic [width-1:0]   ref_val;
   logic [count_w-1:0] mm_q, mm_d;

   always_comb begin
      ref_val = '0;
      case (op_sel_e'(op_sel))
         OP_AND:  ref_val = op_a & op_b;
         OP_OR:   ref_val = op_a | op_b;
         OP_XOR:  ref_val = op_a ^ op_b;
         OP_NAND: ref_val = ~(op_a & op_b);
         default: ref_val = '0;
      endcase
   end

   assign cmp_ok       = (mm_q == '0);
   assign mismatch_cnt = mm_q;
`else
   assign cmp_ok = 1'b1;
`endif

   assign in_ready  = (state_q == S_RUN);
   assign busy      = (state_q == S_RUN) || (state_q == S_CHECK);
   assign done      = (state_q == S_DONE);
   assign pass      = pass_q;
   assign signature = sig_q;
   assign accept    = in_ready & in_valid;

   always_comb begin
      state_d  = state_q;
      nwords_d = nwords_q;
      cnt_d    = cnt_q;
      golden_d = golden_q;
      sig_d    = sig_q;
      pass_d   = pass_q;
`ifdef REF_CMP_EN
      mm_d     = mm_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               nwords_d = num_words;
               golden_d = golden_sig;
               sig_d    = SEED_W;
               cnt_d    = '0;
               pass_d   = 1'b0;
`ifdef REF_CMP_EN
               mm_d     = '0;
`endif
               state_d  = (num_words == '0) ? S_CHECK : S_RUN;
            end
         end
         S_RUN: begin
            if (accept) begin
               sig_d = sig_step;
               cnt_d = cnt_q + CNT_ONE;
`ifdef REF_CMP_EN
               if ((result != ref_val) && (mm_q != {count_w{1'b1}})) begin
                  mm_d = mm_q + CNT_ONE;
               end
`endif
               // The counter never passes num_words-1, so the maximum count needs no wrap.
               if (cnt_q == nwords_q - CNT_ONE) begin
                  state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            pass_d  = (sig_q == golden_q) && cmp_ok;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         nwords_q <= '0;
         cnt_q    <= '0;
         golden_q <= '0;
         sig_q    <= SEED_W;
         pass_q   <= 1'b0;
`ifdef REF_CMP_EN
         mm_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         nwords_q <= nwords_d;
         cnt_q    <= cnt_d;
         golden_q <= golden_d;
         sig_q    <= sig_d;
         pass_q   <= pass_d;
`ifdef REF_CMP_EN
         mm_q     <= mm_d;
`endif
      end
   end

endmodule

// File: tb/tb_bitwise_resp_checker.sv
// tb/tb_bitwise_resp_checker.sv - self-checking bench for bitwise_resp_checker
`timescale 1ns/1ps
module tb_bitwise_resp_checker;

   localparam logic [31:0] P8  = 32'h07;
   localparam logic [31:0] S8  = 32'h00;
   localparam logic [31:0] P32 = 32'h04C11DB7;
   localparam logic [31:0] S32 = 32'hFFFFFFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b0;

   logic       start8 = 1'b0, v8 = 1'b0;
   logic [7:0] nw8 = '0, gold8 = '0, res8 = '0;
   logic       rdy8, busy8, done8, pass8;
   logic [7:0] sig8;

   logic        start32 = 1'b0, v32 = 1'b0;
   logic [7:0]  nw32 = '0;
   logic [31:0] gold32 = '0, res32 = '0;
   logic        rdy32, busy32, done32, pass32;
   logic [31:0] sig32;

`ifdef REF_CMP_EN
   logic [7:0]  opa8, opb8, mm8;
   logic [1:0]  sel8;
   logic [31:0] opa32 = '0, opb32 = '0;
   logic [1:0]  sel32 = 2'b10;
   logic [7:0]  mm32;
   assign opa8 = res8;
   assign opb8 = 8'h00;
   assign sel8 = 2'b10;
`endif

   bitwise_resp_checker #(.width(8), .count_w(8), .MISR_POLY(P8), .SEED(S8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .num_words(nw8), .golden_sig(gold8),
      .in_valid(v8), .in_ready(rdy8), .result(res8),
`ifdef REF_CMP_EN
      .op_a(opa8), .op_b(opb8), .op_sel(sel8), .mismatch_cnt(mm8),
`endif
      .busy(busy8), .done(done8), .pass(pass8), .signature(sig8));

   bitwise_resp_checker #(.width(32), .count_w(8), .MISR_POLY(P32), .SEED(S32)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .num_words(nw32), .golden_sig(gold32),
      .in_valid(v32), .in_ready(rdy32), .result(res32),
`ifdef REF_CMP_EN
      .op_a(opa32), .op_b(opb32), .op_sel(sel32), .mismatch_cnt(mm32),
`endif
      .busy(busy32), .done(done32), .pass(pass32), .signature(sig32));

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [31:0] w,
                                             input int wd, input logic [31:0] poly);
      logic [31:0] mask;
      mask = (wd >= 32) ? 32'hFFFFFFFF : ((32'd1 << wd) - 32'd1);
      return ((s << 1) ^ (s[wd-1] ? poly : 32'd0) ^ w) & mask;
   endfunction

   function automatic logic [31:0] op_ref(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
      case (s)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   // Reference for the 8-bit instance: a run either accepts words, waits one
   // cycle to judge, or sits finished.
   bit         m_run = 0, m_chk = 0, m_done = 0, m_pass = 0;
   logic [7:0] m_sig = 8'h00, m_gold = 8'h00;
   int         m_n = 0, m_got = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run <= 0; m_chk <= 0; m_done <= 0; m_pass <= 0;
         m_sig <= S8[7:0]; m_got <= 0;
      end else if (m_run) begin
         if (v8) begin
            m_sig <= misr_next({24'd0, m_sig}, {24'd0, res8}, 8, P8);
            m_got <= m_got + 1;
            if (m_got + 1 == m_n) begin
               m_run <= 0;
               m_chk <= 1;
            end
         end
      end else if (m_chk) begin
         m_chk  <= 0;
         m_done <= 1;
         m_pass <= (m_sig == m_gold);
      end else if (start8) begin
         m_n    <= int'(nw8);
         m_gold <= gold8;
         m_sig  <= S8[7:0];
         m_got  <= 0;
         m_done <= 0;
         m_pass <= 0;
         m_run  <= (nw8 != 8'd0);
         m_chk  <= (nw8 == 8'd0);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cyc in_ready", {31'd0, rdy8}, {31'd0, m_run});
         chk("cyc busy", {31'd0, busy8}, {31'd0, m_run | m_chk});
         chk("cyc done", {31'd0, done8}, {31'd0, m_done});
         chk("cyc signature", {24'd0, sig8}, {24'd0, m_sig});
         if (m_done) chk("cyc pass", {31'd0, pass8}, {31'd0, m_pass});
`ifdef REF_CMP_EN
         chk("cyc mismatch_cnt", {24'd0, mm8}, 32'd0);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run8(input int n, input logic [7:0] g);
      start8 = 1'b1; nw8 = n[7:0]; gold8 = g;
      tick();
      start8 = 1'b0;
   endtask

   task automatic send8(input logic [7:0] w);
      v8 = 1'b1; res8 = w;
      tick();
      v8 = 1'b0;
   endtask

   task automatic send32(input logic [31:0] r, input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
`ifdef REF_CMP_EN
      opa32 = a; opb32 = b; sel32 = s;
`endif
      v32 = 1'b1; res32 = r;
      tick();
      v32 = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   logic [7:0]  wl [0:254];
   logic [31:0] wl32 [0:3];

   initial begin
      logic [7:0]  exp8, g8;
      logic [31:0] exp32, a, b, r;
      logic [1:0]  s;
      int          n, t;

      repeat (2) @(posedge clk);
      #1;
      chk("rst in_ready", {31'd0, rdy8}, 32'd0);
      chk("rst busy", {31'd0, busy8}, 32'd0);
      chk("rst done", {31'd0, done8}, 32'd0);
      chk("rst pass", {31'd0, pass8}, 32'd0);
      chk("rst signature8", {24'd0, sig8}, 32'd0);
      chk("rst signature32", sig32, 32'hFFFFFFFF);
      @(negedge clk); #1 rst_n = 1'b1;
      tick();

      // zero-length run
      start_run8(0, 8'h00);
      chk("s1 done early", {31'd0, done8}, 32'd0);
      chk("s1 busy", {31'd0, busy8}, 32'd1);
      tick();
      chk("s1 done", {31'd0, done8}, 32'd1);
      chk("s1 pass", {31'd0, pass8}, 32'd1);
      chk("s1 sig", {24'd0, sig8}, 32'h00);

      // two-word run
      start_run8(2, 8'hB5);
      chk("s2 in_ready", {31'd0, rdy8}, 32'd1);
      send8(8'h5A);
      chk("s2 sig1", {24'd0, sig8}, 32'h5A);
      send8(8'h01);
      chk("s2 sig2", {24'd0, sig8}, 32'hB5);
      chk("s2 done early", {31'd0, done8}, 32'd0);
      tick();
      chk("s2 done", {31'd0, done8}, 32'd1);
      chk("s2 pass", {31'd0, pass8}, 32'd1);

      // stalls between words
      start_run8(2, 8'hB5);
      send8(8'h5A);
      repeat (3) tick();
      chk("s4 stall sig", {24'd0, sig8}, 32'h5A);
      chk("s4 stall busy", {31'd0, busy8}, 32'd1);
      send8(8'h01);
      chk("s4 done early", {31'd0, done8}, 32'd0);
      tick();
      chk("s4 done", {31'd0, done8}, 32'd1);
      chk("s4 sig", {24'd0, sig8}, 32'hB5);
      chk("s4 pass", {31'd0, pass8}, 32'd1);

      // three words with MSB feedback
      start_run8(3, 8'h6D);
      send8(8'h5A); send8(8'h01); send8(8'h00);
      tick();
      chk("s3a pass", {31'd0, pass8}, 32'd1);
      chk("s3a sig", {24'd0, sig8}, 32'h6D);
      start_run8(3, 8'h6C);
      send8(8'h5A); send8(8'h01); send8(8'h00);
      // start held from the CHECK cycle: ignored on DONE entry, honoured one cycle later
      start8 = 1'b1; nw8 = 8'd0; gold8 = 8'h00;
      tick();
      chk("s3b done", {31'd0, done8}, 32'd1);
      chk("s3b pass", {31'd0, pass8}, 32'd0);
      chk("s3b sig", {24'd0, sig8}, 32'h6D);
      tick();
      start8 = 1'b0;
      chk("restart busy", {31'd0, busy8}, 32'd1);
      chk("restart sig", {24'd0, sig8}, 32'h00);
      tick();
      chk("restart pass", {31'd0, pass8}, 32'd1);

      // maximum word count
      exp8 = S8[7:0];
      for (int i = 0; i < 255; i++) begin
         wl[i] = 8'($urandom);
         exp8 = 8'(misr_next({24'd0, exp8}, {24'd0, wl[i]}, 8, P8));
      end
      start_run8(255, exp8);
      for (int i = 0; i < 254; i++) send8(wl[i]);
      chk("max busy", {31'd0, rdy8}, 32'd1);
      send8(wl[254]);
      tick();
      chk("max done", {31'd0, done8}, 32'd1);
      chk("max pass", {31'd0, pass8}, 32'd1);

      // randomized runs with gaps, idle junk and ignored start pulses
      for (int r_i = 0; r_i < 40; r_i++) begin
         n = $urandom_range(0, 12);
         exp8 = S8[7:0];
         for (int i = 0; i < n; i++) begin
            wl[i] = 8'($urandom);
            exp8 = 8'(misr_next({24'd0, exp8}, {24'd0, wl[i]}, 8, P8));
         end
         g8 = ($urandom_range(0, 1) == 1) ? exp8 : 8'($urandom);
         t = $urandom_range(0, 3);
         for (int k = 0; k < t; k++) begin
            v8 = 1'($urandom); res8 = 8'($urandom);
            tick();
         end
         v8 = 1'b0;
         start_run8(n, g8);
         for (int i = 0; i < n; i++) begin
            t = $urandom_range(0, 2);
            for (int k = 0; k < t; k++) begin
               start8 = 1'($urandom); nw8 = 8'($urandom); gold8 = 8'($urandom);
               tick();
            end
            start8 = 1'b0;
            send8(wl[i]);
         end
         t = 0;
         while (!done8 && t < 10) begin
            tick();
            t++;
         end
         chk("rand done", {31'd0, done8}, 32'd1);
         chk("rand pass", {31'd0, pass8}, {31'd0, g8 == exp8});
         chk("rand sig", {24'd0, sig8}, {24'd0, exp8});
      end

      // mid-run reset on the 32-bit instance
      start32 = 1'b1; nw32 = 8'd4; gold32 = 32'd0;
      tick();
      start32 = 1'b0;
      r = $urandom; send32(r, r, 32'd0, 2'b10);
      r = $urandom; send32(r, r, 32'd0, 2'b10);
      chk("s5 busy before reset", {31'd0, busy32}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("s5 rst in_ready", {31'd0, rdy32}, 32'd0);
      chk("s5 rst busy", {31'd0, busy32}, 32'd0);
      chk("s5 rst done", {31'd0, done32}, 32'd0);
      chk("s5 rst pass", {31'd0, pass32}, 32'd0);
      chk("s5 rst sig", sig32, 32'hFFFFFFFF);
`ifdef REF_CMP_EN
      chk("s5 rst mismatch_cnt", {24'd0, mm32}, 32'd0);
`endif
      @(negedge clk); #1 rst_n = 1'b1;
      tick();
      exp32 = S32;
      for (int i = 0; i < 3; i++) begin
         wl32[i] = $urandom;
         exp32 = misr_next(exp32, wl32[i], 32, P32);
      end
      start32 = 1'b1; nw32 = 8'd3; gold32 = exp32;
      tick();
      start32 = 1'b0;
      chk("s5 in_ready", {31'd0, rdy32}, 32'd1);
      for (int i = 0; i < 3; i++) send32(wl32[i], wl32[i], 32'd0, 2'b10);
      tick();
      chk("s5 done", {31'd0, done32}, 32'd1);
      chk("s5 pass", {31'd0, pass32}, 32'd1);
      chk("s5 sig", sig32, exp32);

`ifdef REF_CMP_EN
      // AND operands with one wrong result: golden matches, but pass must drop
      a = $urandom; b = $urandom;
      wl32[0] = 32'h00000000;
      wl32[1] = 32'h11111111;
      wl32[2] = a & b;
      wl32[3] = ((a ^ 32'h5555AAAA) & b) ^ 32'h00010000;
      exp32 = S32;
      for (int i = 0; i < 4; i++) exp32 = misr_next(exp32, wl32[i], 32, P32);
      start32 = 1'b1; nw32 = 8'd4; gold32 = exp32;
      tick();
      start32 = 1'b0;
      chk("s6 mm cleared", {24'd0, mm32}, 32'd0);
      send32(wl32[0], 32'hF0F0F0F0, 32'h0F0F0F0F, 2'b00);
      send32(wl32[1], 32'h11111111, 32'h33333333, 2'b00);
      send32(wl32[2], a, b, 2'b00);
      send32(wl32[3], a ^ 32'h5555AAAA, b, 2'b00);
      tick();
      chk("s6 done", {31'd0, done32}, 32'd1);
      chk("s6 mismatch_cnt", {24'd0, mm32}, 32'd1);
      chk("s6 pass", {31'd0, pass32}, 32'd0);
      chk("s6 sig", sig32, exp32);

      // all four ops with correct results
      exp32 = S32;
      start32 = 1'b1; nw32 = 8'd4; gold32 = 32'd0;
      for (int i = 0; i < 4; i++) begin
         wl32[i] = op_ref(2'(i), 32'h0F0F3C3C ^ (32'(i) << 8), 32'h33CC55AA);
         exp32 = misr_next(exp32, wl32[i], 32, P32);
      end
      gold32 = exp32;
      tick();
      start32 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s = 2'(i);
         send32(wl32[i], 32'h0F0F3C3C ^ (32'(i) << 8), 32'h33CC55AA, s);
      end
      tick();
      chk("ops mismatch_cnt", {24'd0, mm32}, 32'd0);
      chk("ops pass", {31'd0, pass32}, 32'd1);
`endif

      repeat (2) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
